// File: rtl/bp_fe_btb_update_if.sv
// bp_fe_btb_update_if
//
// Groups the resolved-branch feedback handshake and the BTB write command
// of bp_fe_btb_update. Signal names keep the block's port naming, so the
// direction suffixes are relative to the bp_fe_btb_update instance.
//
//   fb_v_i        feedback valid (back end -> block)
//   fb_ready_o    feedback ready (block -> back end)
//   fb_pc_i       pc of the resolved branch
//   fb_target_i   resolved target
//   fb_taken_i    branch resolved taken
//   btb_w_v_o     BTB write valid, registered
//   btb_idx_w_o   BTB write index, registered
//   btb_target_o  BTB write data, registered
//
// Modports: slave is the bp_fe_btb_update side, master is the driving side.
interface bp_fe_btb_update_if #(
    parameter int unsigned eaddr_width_p   = 39,
    parameter int unsigned btb_idx_width_p = 9
);
    logic                       fb_v_i;
    logic                       fb_ready_o;
    logic [eaddr_width_p-1:0]   fb_pc_i;
    logic [eaddr_width_p-1:0]   fb_target_i;
    logic                       fb_taken_i;
    logic                       btb_w_v_o;
    logic [btb_idx_width_p-1:0] btb_idx_w_o;
    logic [eaddr_width_p-1:0]   btb_target_o;

    modport slave (
        input  fb_v_i, fb_pc_i, fb_target_i, fb_taken_i,
        output fb_ready_o, btb_w_v_o, btb_idx_w_o, btb_target_o
    );

    modport master (
        output fb_v_i, fb_pc_i, fb_target_i, fb_taken_i,
        input  fb_ready_o, btb_w_v_o, btb_idx_w_o, btb_target_o
    );
endinterface

// File: rtl/bp_fe_btb_update.sv
// bp_fe_btb_update
//
// Write side of the front-end BTB. Resolved-branch feedback arrives over a
// valid/ready handshake; taken branches are queued as {idx, target} in a
// small FIFO and drained as registered single-cycle BTB write commands.
// The pc generator can hold (suppress pops) or flush (drop the queue).
//
// Ports:
//   clk_i      clock, all state on the rising edge
//   reset_n_i  synchronous active-low reset
//   hold_i     suppress the pop decision this cycle
//   flush_i    discard all queued feedback; refuses input this cycle
//   empty_o    FIFO empty and no write on the output
//   fb         bp_fe_btb_update_if.slave: feedback in, BTB write out
//
// Optional feature: define BP_FE_BTB_UPDATE_DEDUP_EN to skip a write whose
// {idx, target} equals the last write issued (entry is still popped).
module bp_fe_btb_update #(
    // Parent must set this to the core's effective address width.
    parameter int unsigned eaddr_width_p   = 39,
    parameter int unsigned btb_idx_width_p = 9,
    parameter int unsigned pc_lsb_p        = 2,
    // Power of two, at least 2.
    parameter int unsigned fifo_els_p      = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     hold_i,
    input  logic                     flush_i,
    output logic                     empty_o,
    bp_fe_btb_update_if.slave        fb
);

    localparam int unsigned ptr_width_lp = $clog2(fifo_els_p);

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

    state_e state_d, state_q;

    logic [btb_idx_width_p-1:0] mem_idx_q [fifo_els_p];
    logic [eaddr_width_p-1:0]   mem_tgt_q [fifo_els_p];

    logic [ptr_width_lp-1:0] wptr_d, wptr_q, rptr_d, rptr_q;
    logic [ptr_width_lp:0]   count_d, count_q;

    logic [btb_idx_width_p-1:0] idx_q;
    logic [eaddr_width_p-1:0]   tgt_q;

    logic                       full, fifo_empty, ready, enq, pop;
    logic [btb_idx_width_p-1:0] enq_idx, head_idx;
    logic [eaddr_width_p-1:0]   head_tgt;
    logic                       btb_w_v;
    logic                       unused_pc;

    assign full       = (count_q == (ptr_width_lp + 1)'(fifo_els_p));
    assign fifo_empty = (count_q == '0);

    // No full-and-pop bypass: a full FIFO refuses even if it pops this cycle.
    assign ready = !full && !flush_i;
    assign enq   = fb.fb_v_i && ready && fb.fb_taken_i;

    assign enq_idx   = fb.fb_pc_i[pc_lsb_p +: btb_idx_width_p];
    assign unused_pc = ^fb.fb_pc_i;
    assign head_idx  = mem_idx_q[rptr_q];
    assign head_tgt  = mem_tgt_q[rptr_q];

    // Pop decision is made fresh every cycle from occupancy, hold and flush.
    always_comb begin
        state_d = StIdle;
        pop     = 1'b0;
        if (flush_i) begin
            state_d = StIdle;
        end else if (!fifo_empty) begin
            if (hold_i) begin
                state_d = StHold;
            end else begin
                state_d = StIssue;
                pop     = 1'b1;
            end
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (enq) wptr_d = wptr_q + 1'b1;
            if (pop) rptr_d = rptr_q + 1'b1;
            unique case ({enq, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_idx_q[wptr_q] <= enq_idx;
            mem_tgt_q[wptr_q] <= fb.fb_target_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            if (pop) begin
                idx_q <= head_idx;
                tgt_q <= head_tgt;
            end
        end
    end

`ifdef BP_FE_BTB_UPDATE_DEDUP_EN
    logic                       last_v_q;
    logic [btb_idx_width_p-1:0] last_idx_q;
    logic [eaddr_width_p-1:0]   last_tgt_q;
    logic                       dup, dup_q;

    assign dup = last_v_q && (last_idx_q == head_idx) && (last_tgt_q == head_tgt);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i || flush_i) begin
            last_v_q   <= 1'b0;
            last_idx_q <= '0;
            last_tgt_q <= '0;
            dup_q      <= 1'b0;
        end else begin
            dup_q <= pop && dup;
            if (pop && !dup) begin
                last_v_q   <= 1'b1;
                last_idx_q <= head_idx;
                last_tgt_q <= head_tgt;
            end
        end
    end

    // A duplicate still pops; only the write strobe is masked. idx/target
    // load identical values, so the outputs stay stable.
    assign btb_w_v = (state_q == StIssue) && !dup_q;
`else
    assign btb_w_v = (state_q == StIssue);
`endif

    assign fb.fb_ready_o   = ready;
    assign fb.btb_w_v_o    = btb_w_v;
    assign fb.btb_idx_w_o  = idx_q;
    assign fb.btb_target_o = tgt_q;
    assign empty_o         = fifo_empty && !btb_w_v;

endmodule

// File: tb/tb_bp_fe_btb_update.sv
module tb_bp_fe_btb_update;

    localparam int EW    = 32;
    localparam int IW    = 9;
    localparam int LSB   = 2;
    localparam int DEPTH = 4;
`ifdef BP_FE_BTB_UPDATE_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic hold;
    logic flush;
    logic empty;

    always #5 clk = ~clk;

    bp_fe_btb_update_if #(.eaddr_width_p(EW), .btb_idx_width_p(IW)) fb_if ();

    bp_fe_btb_update #(
        .eaddr_width_p  (EW),
        .btb_idx_width_p(IW),
        .pc_lsb_p       (LSB),
        .fifo_els_p     (DEPTH)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .hold_i   (hold),
        .flush_i  (flush),
        .empty_o  (empty),
        .fb       (fb_if)
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [EW-1:0] tgt;
    } ent_t;

    // Reference model: queued taken entries, expected writes, dedup memory.
    ent_t          mq[$];
    ent_t          exp_q[$];
    ent_t          last_w;
    bit            last_v;
    logic [IW-1:0] out_idx;
    logic [EW-1:0] out_tgt;

    int            n_tests;
    int            n_fail;
    int            n_writes;
    bit            mon_en;
    logic [IW-1:0] seen_idx;
    logic [EW-1:0] seen_tgt;

    function automatic logic [IW-1:0] idx_of(input logic [EW-1:0] pc);
        logic [31:0] t;
        t = (32'(pc) >> LSB) % (32'd1 << IW);
        return t[IW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applied at every rising edge with the inputs of the ending cycle.
    task automatic model_update();
        ent_t e;
        bit   was_full;
        if (!reset_n) begin
            mq.delete();
            last_v  = 1'b0;
            out_idx = '0;
            out_tgt = '0;
        end else if (flush) begin
            mq.delete();
            last_v = 1'b0;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (!hold && mq.size() > 0) begin
                e = mq.pop_front();
                out_idx = e.idx;
                out_tgt = e.tgt;
                if (!(DEDUP && last_v && e == last_w)) begin
                    exp_q.push_back(e);
                    last_w = e;
                    last_v = 1'b1;
                end
            end
            if (fb_if.fb_v_i && !was_full && fb_if.fb_taken_i)
                mq.push_back('{idx: idx_of(fb_if.fb_pc_i), tgt: fb_if.fb_target_i});
        end
    endtask

    // Monitor: pops the scoreboard whenever a write is presented.
    initial begin
        ent_t e;
        bit   exp_wv;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_wv = (exp_q.size() > 0);
                check("btb_w_v", fb_if.btb_w_v_o, exp_wv);
                if (fb_if.btb_w_v_o) begin
                    n_writes++;
                    seen_idx = fb_if.btb_idx_w_o;
                    seen_tgt = fb_if.btb_target_o;
                end
                if (exp_wv) begin
                    e = exp_q.pop_front();
                    if (fb_if.btb_w_v_o) begin
                        check("write_idx", fb_if.btb_idx_w_o, e.idx);
                        check("write_target", fb_if.btb_target_o, e.tgt);
                    end
                end else begin
                    check("idx_stable", fb_if.btb_idx_w_o, out_idx);
                    check("target_stable", fb_if.btb_target_o, out_tgt);
                end
                check("fb_ready", fb_if.fb_ready_o, (mq.size() < DEPTH) && !flush);
                check("empty", empty, (mq.size() == 0) && !exp_wv);
            end
        end
    end

    task automatic step(input logic v, input logic [EW-1:0] pc, input logic [EW-1:0] tgt,
                        input logic tk, input logic h, input logic fl, input logic rn,
                        output bit acc);
        fb_if.fb_v_i       = v;
        fb_if.fb_pc_i      = pc;
        fb_if.fb_target_i  = tgt;
        fb_if.fb_taken_i   = tk;
        hold               = h;
        flush              = fl;
        reset_n            = rn;
        acc = v && rn && !fl && (mq.size() < DEPTH);
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic idle(input int n, input logic h);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, h, 1'b0, 1'b1, acc);
    endtask

    // Holds valid until accepted, bounded by a cycle budget.
    task automatic send(input logic [EW-1:0] pc, input logic [EW-1:0] tgt, input logic tk,
                        input logic h);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) step(1'b1, pc, tgt, tk, h, 1'b0, 1'b1, acc);
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got not-accepted, expected accepted pc=%0h", pc);
        end
    endtask

    initial begin
        int  w0;
        bit  acc;
        n_tests  = 0;
        n_fail   = 0;
        n_writes = 0;
        mon_en   = 1'b0;
        last_v   = 1'b0;
        out_idx  = '0;
        out_tgt  = '0;

        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        mon_en = 1'b1;
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        idle(1, 1'b0);

        // Single write
        w0 = n_writes;
        send(32'h0000_1008, 32'h0000_2000, 1'b1, 1'b0);
        idle(4, 1'b0);
        check("single_count", 64'(n_writes - w0), 64'd1);
        check("single_idx", seen_idx, 64'h002);
        check("single_target", seen_tgt, 64'h2000);

        // Backpressure: 4 fill under hold, 5th refused until hold released
        w0 = n_writes;
        for (int i = 0; i < 4; i++) send(32'h100 + 32'(i * 4), 32'h8000 + 32'(i), 1'b1, 1'b1);
        step(1'b1, 32'h110, 32'h8004, 1'b1, 1'b1, 1'b0, 1'b1, acc);
        send(32'h110, 32'h8004, 1'b1, 1'b0);
        idle(8, 1'b0);
        check("backpressure_count", 64'(n_writes - w0), 64'd5);
        check("backpressure_last", seen_tgt, 64'h8004);

        // Not-taken filter
        w0 = n_writes;
        for (int i = 0; i < 8; i++)
            send(32'h2000 + 32'(i * 4), 32'h9000 + 32'(i), (i % 2) == 0, 1'b0);
        idle(6, 1'b0);
        check("filter_count", 64'(n_writes - w0), 64'd4);

        // Flush with concurrent valid
        w0 = n_writes;
        for (int i = 0; i < 3; i++) send(32'h3000 + 32'(i * 4), 32'hA000 + 32'(i), 1'b1, 1'b1);
        step(1'b1, 32'h3100, 32'hA100, 1'b1, 1'b1, 1'b1, 1'b1, acc);
        idle(6, 1'b0);
        check("flush_count", 64'(n_writes - w0), 64'd0);
        send(32'h3200, 32'hA200, 1'b1, 1'b0);
        idle(4, 1'b0);
        check("post_flush_count", 64'(n_writes - w0), 64'd1);
        check("post_flush_target", seen_tgt, 64'hA200);

        // Dedup
        w0 = n_writes;
        send(32'h4000, 32'hB000, 1'b1, 1'b0);
        send(32'h4000, 32'hB000, 1'b1, 1'b0);
        idle(4, 1'b0);
        check("dedup_same", 64'(n_writes - w0), DEDUP ? 64'd1 : 64'd2);
        w0 = n_writes;
        send(32'h4000, 32'hB004, 1'b1, 1'b0);
        send(32'h4000, 32'hB008, 1'b1, 1'b0);
        idle(4, 1'b0);
        check("dedup_changed", 64'(n_writes - w0), 64'd2);

        // Reset mid-drain with 2 entries remaining
        w0 = n_writes;
        for (int i = 0; i < 4; i++) send(32'h5000 + 32'(i * 4), 32'hC000 + 32'(i), 1'b1, 1'b1);
        idle(2, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        idle(6, 1'b0);
        check("reset_drain_count", 64'(n_writes - w0), 64'd2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [EW-1:0] pc, tgt;
            pc  = (($urandom_range(0, 3) == 0) ? 32'h6000 : $urandom) & ~32'h3;
            tgt = ($urandom_range(0, 2) == 0) ? 32'hD000 : $urandom;
            step($urandom_range(0, 3) != 0, pc, tgt, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 99) != 0, acc);
        end
        idle(10, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_fe_btb_update.md
# bp_fe_btb_update

Write-side companion of the front-end branch target buffer. Accepts resolved-branch feedback from the back end over a valid/ready handshake, buffers it in a small FIFO, and turns taken branches into registered single-cycle BTB write commands (index plus target). It is the only writer of the BTB. The fetch-side pc generator can hold or flush it around redirects.

## Interface
Parameters:
- `eaddr_width_p`, "inv": effective address width. Must be set by the parent.
- `btb_idx_width_p`, 9: BTB index width. Must match the BTB instance.
- `pc_lsb_p`, 2: lowest pc bit used in the index.
- `fifo_els_p`, 4: feedback FIFO depth. Power of two, at least 2.

Ports:
- `clk_i`  in  1  clock. One clock; all state updates on its rising edge.
- `reset_n_i`  in  1  reset, synchronous and active-low.
- `fb_v_i`  in  1  feedback valid.
- `fb_ready_o`  out  1  feedback ready.
- `fb_pc_i`  in  `eaddr_width_p`  pc of the branch site.
- `fb_target_i`  in  `eaddr_width_p`  resolved target.
- `fb_taken_i`  in  1  branch resolved taken.
- `hold_i`  in  1  pc generator requests that writes be suppressed this cycle.
- `flush_i`  in  1  discard all queued feedback.
- `btb_w_v_o`  out  1  BTB write valid. Registered.
- `btb_idx_w_o`  out  `btb_idx_width_p`  BTB write index. Registered.
- `btb_target_o`  out  `eaddr_width_p`  BTB write data. Registered.
- `empty_o`  out  1  FIFO empty and no write outstanding.

## Operation
- **Accept.** A transfer occurs when `fb_v_i & fb_ready_o`.
  - `fb_ready_o = !full & !flush_i`.
  - There is no full-and-pop bypass: when the FIFO is full, ready stays low even if an entry pops in the same cycle.
- **Filtering.**
  - Only transfers with `fb_taken_i=1` are enqueued.
  - Not-taken transfers are handshaken (ready honoured) and then dropped.
- **Index.** `idx = pc[pc_lsb_p+btb_idx_width_p-1 : pc_lsb_p]`, computed at enqueue. Each entry stores {idx, target}.
- **FSM states:**
  - IDLE: FIFO empty. `btb_w_v_o` is 0 next cycle.
  - ISSUE: head valid and `!hold_i`. Pop the head. Next cycle, `btb_w_v_o=1` with the head's idx/target.
  - HOLD: head valid and `hold_i`. No pop, and `btb_w_v_o=0` next cycle.
  - The state is re-evaluated every cycle from FIFO occupancy, `hold_i` and `flush_i`.
- **Flush priority.** `flush_i` beats everything in the same cycle:
  - FIFO pointers and count clear.
  - No pop, no enqueue.
  - `btb_w_v_o` is 0 next cycle.
  - A write already registered (visible on `btb_w_v_o` in the flush cycle) still completes.
- **Simultaneous enqueue and pop** (not full): count unchanged, pointers both advance.
- **Pointer wrap.** Pointers are `log2(fifo_els_p)` bits and wrap naturally.
  - A separate occupancy counter of `log2(fifo_els_p)+1` bits distinguishes full from empty.
  - The count never exceeds `fifo_els_p` and never underflows.
- **`empty_o`** = (count==0) & !`btb_w_v_o`.

## Timing
- **Reset values:**
  - `btb_w_v_o=0`, `btb_idx_w_o=0`, `btb_target_o=0`.
  - `empty_o=1`.
  - `fb_ready_o=1` (unless `flush_i` is high).
  - FSM in IDLE, count 0.
- **Reset mid-operation** discards all queued entries; any in-flight write is dropped the next cycle.
- **Latency.** Feedback accepted at edge N into an empty FIFO with `hold_i=0` appears as a write in cycle N+1 (pop at edge N+1, output registered), so `btb_w_v_o` is high after edge N+1. Minimum two-edge latency.
- **Throughput.** One write per cycle sustained.
- **`btb_w_v_o`** is high exactly one cycle per issued entry.
- **`hold_i`** is sampled combinationally in the cycle of the pop decision. No combinational path exists from any input to `btb_w_*_o`.
- **Output stability.** `btb_idx_w_o` and `btb_target_o` keep their last written values while `btb_w_v_o=0`.

## Configuration
- `BP_FE_BTB_UPDATE_DEDUP_EN` defined:
  - The block keeps a last-written register {idx, target, valid}. It is cleared by reset and by `flush_i`, and updated on every issued write.
  - An ISSUE whose head matches it exactly pops the entry without asserting `btb_w_v_o`.
- Undefined: every taken entry produces a write, and the register is not built.

## Test plan
- **Single write.** After reset, send one taken feedback with pc=0x0000_1008, target=0x0000_2000, `hold_i=0` -> exactly one cycle of `btb_w_v_o=1`, idx=0x002, target=0x2000, two edges after acceptance. `empty_o` returns to 1.
- **Backpressure.** With `hold_i=1`, send 5 taken feedbacks (`fifo_els_p=4`) -> `fb_ready_o` drops after the 4th. Release hold -> 4 back-to-back writes in order. The 5th is accepted once space frees and written last.
- **Not-taken filter.** Alternate taken and not-taken feedback, 8 transfers -> only 4 writes, each with a taken entry's idx/target.
- **Flush.** Queue 3 entries under hold, then assert `flush_i` together with `fb_v_i` -> incoming entry refused. No writes after the flush, `empty_o=1` the next cycle, and new feedback afterwards is written normally.
- **Dedup.** Send the same taken pc/target twice:
  - Macro defined -> one write.
  - Undefined -> two writes.
  - Any change to the target -> two writes in both builds.
- **Reset mid-drain.** Assert `reset_n_i=0` while 2 entries remain -> `btb_w_v_o=0` and `empty_o=1` the next cycle, and nothing is written after reset is released.
